parking_slot_controller: RTL and testbench
==========================================

# parking_slot_controller

Sequential controller for an 8-slot parking lot. It accepts car-entry and car-exit request pulses and arbitrates between them, with exit taking priority. It keeps the slot occupancy register, allocates the lowest free slot on entry and frees the named slot on exit. It sequences the entry and exit gates with a fixed open time, and drives the one-hot slot location shown to an entering driver.

## Interface
- GATE_CYCLES, default 4: cycles a gate stays open per serviced car. Legal range is 1..15.
- clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- entry_req  in  1  single-cycle pulse: a car is at the entry.
- exit_req  in  1  single-cycle pulse: a car is leaving.
- exit_number  in  3  slot being vacated; sampled with exit_req.
- entry_grant  out  1  one-cycle pulse: a slot has been allocated.
- entry_denied  out  1  one-cycle pulse: entry was refused because the lot is full.
- entry_slot  out  3  binary index of the last allocated slot.
- entry_location  out  8  one-hot form of entry_slot; bit i = slot i.
- exit_done  out  1  one-cycle pulse: exit accepted, slot freed.
- exit_error  out  1  one-cycle pulse: exit named an empty slot.
- entry_gate  out  1  entry gate open.
- exit_gate  out  1  exit gate open.
- occupancy  out  8  bit i = 1 means slot i is occupied.
- free_count  out  4  number of zero bits in occupancy (0..8).
- full  out  1  occupancy == 8'hFF.
- empty  out  1  occupancy == 8'h00.

## Operation
- Reset values:
  - All pulses, both gates, entry_slot, entry_location and occupancy are 0.
  - free_count = 8, full = 0, empty = 1.
  - Both pending flags are 0 and the FSM is in IDLE.
- Request latching:
  - entry_req sets pend_entry.
  - exit_req sets pend_exit and captures exit_number into exit_idx.
  - A pulse arriving while its flag is already set is dropped, and exit_idx is not overwritten.
  - If a pulse arrives on the same edge its flag is cleared by service, the new request is latched (set wins).
- FSM states: IDLE, ENTRY_OPEN, EXIT_OPEN.
- IDLE behaviour on each edge:
  - pend_exit set and occupancy[exit_idx] = 1:
    - Clear occupancy[exit_idx] and clear pend_exit.
    - Pulse exit_done.
    - Load the counter with GATE_CYCLES-1 and go to EXIT_OPEN.
  - pend_exit set and occupancy[exit_idx] = 0:
    - Clear pend_exit and pulse exit_error.
    - Stay in IDLE; occupancy is unchanged and the gate stays closed.
  - Otherwise, pend_entry set and full:
    - Clear pend_entry and pulse entry_denied.
    - Stay in IDLE.
  - Otherwise, pend_entry set and not full:
    - k = lowest index with occupancy[k] = 0. Set occupancy[k] and clear pend_entry.
    - entry_slot = k, entry_location = 1<<k.
    - Pulse entry_grant.
    - Load the counter and go to ENTRY_OPEN.
- Arbitration: one service per IDLE edge, and exit always beats entry. A pending entry left behind after an exit is serviced at the next IDLE edge.
- ENTRY_OPEN / EXIT_OPEN:
  - The matching gate is 1.
  - The counter decrements each cycle; when it is 0, the FSM returns to IDLE and the gate drops.
  - New requests still latch into the pending flags during this time.
- entry_slot and entry_location hold their value until the next grant.
- free_count, full and empty are registered and always consistent with occupancy in the same cycle.

## Timing
- Edge numbering: request pulse in the cycle before edge E0, so it is latched at E0.
- If the FSM is IDLE at edge E1 = E0+1:
  - Any response pulse is high for exactly the cycle after E1.
  - occupancy, free_count and full/empty update at E1.
- Gate timing: the gate is high for exactly GATE_CYCLES cycles starting after E1. The FSM is back in IDLE at edge E1+GATE_CYCLES.
- Earliest next service is edge E1+GATE_CYCLES+1. Error and denied cases take no gate time, so the next service can come at E1+1.
- Request-to-response latency when idle is 2 edges.
- Reset asserted mid-operation wins at that edge: any open gate closes, pending requests are discarded and occupancy is cleared.

## Test plan
- Reset, then one entry_req: entry_grant after 2 edges with entry_slot = 0 and entry_location = 8'h01. entry_gate is high for 4 cycles; occupancy = 8'h01, free_count = 7, empty = 0.
- Eight entries, spaced out: slots 0..7 are allocated in order and full = 1. A ninth entry_req gives entry_denied with occupancy still 8'hFF and no gate.
- occupancy = 8'h0F, exit_req with exit_number = 2: exit_done, occupancy = 8'h0B, exit_gate high for 4 cycles. A following entry is allocated slot 2 (lowest free).
- exit_req and entry_req in the same cycle with occupancy = 8'hFF and exit_number = 5:
  - First, exit_done frees slot 5 (EXIT_OPEN for 4 cycles).
  - Then entry_grant with entry_slot = 5; no entry_denied.
- exit_req with exit_number = 6 while slot 6 is empty: exit_error pulse, occupancy unchanged, exit_gate stays 0.
- reset asserted in the 2nd cycle of ENTRY_OPEN with an exit pending: the next cycle has all outputs at reset values, and nothing is serviced afterwards.

Source files
------------

// File: rtl/parking_slot_controller.sv
`default_nettype none
// ============================================================================
// Module   : parking_slot_controller
// Purpose  : 8-slot parking lot controller. Latches entry/exit request
//            pulses, serves one request per idle cycle with exit taking
//            priority, tracks slot occupancy, allocates the lowest free slot
//            and holds the matching gate open for GATE_CYCLES cycles.
// Revision : 1.0 - initial release
// ============================================================================
module parking_slot_controller #(
  parameter int GATE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       entry_req,
  input  logic       exit_req,
  input  logic [2:0] exit_number,
  output logic       entry_grant,
  output logic       entry_denied,
  output logic [2:0] entry_slot,
  output logic [7:0] entry_location,
  output logic       exit_done,
  output logic       exit_error,
  output logic       entry_gate,
  output logic       exit_gate,
  output logic [7:0] occupancy,
  output logic [3:0] free_count,
  output logic       full,
  output logic       empty
);

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_ENTRY_OPEN = 2'd1,
    ST_EXIT_OPEN  = 2'd2
  } state_t;

  localparam logic [3:0] C_GATE_LOAD = 4'(GATE_CYCLES - 1);

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       pend_entry_q, pend_entry_d;
  logic       pend_exit_q, pend_exit_d;
  logic [2:0] exit_idx_q, exit_idx_d;
  logic [7:0] occ_q, occ_d;
  logic [3:0] free_count_q, free_count_d;
  logic       full_q, full_d;
  logic       empty_q, empty_d;
  logic       entry_grant_q, entry_grant_d;
  logic       entry_denied_q, entry_denied_d;
  logic       exit_done_q, exit_done_d;
  logic       exit_error_q, exit_error_d;
  logic       entry_gate_q, entry_gate_d;
  logic       exit_gate_q, exit_gate_d;
  logic [2:0] entry_slot_q, entry_slot_d;
  logic [7:0] entry_loc_q, entry_loc_d;

  logic [2:0] free_idx;
  logic [3:0] ones_d;
  logic       clr_entry;
  logic       clr_exit;

  // Priority search for the lowest-numbered empty slot.
  always_comb begin
    free_idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (!occ_q[i]) free_idx = 3'(i);
    end
  end

  // Next-state logic: service arbitration, gate timing and request latching.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    occ_d          = occ_q;
    entry_slot_d   = entry_slot_q;
    entry_loc_d    = entry_loc_q;
    entry_gate_d   = entry_gate_q;
    exit_gate_d    = exit_gate_q;
    entry_grant_d  = 1'b0;
    entry_denied_d = 1'b0;
    exit_done_d    = 1'b0;
    exit_error_d   = 1'b0;
    clr_entry      = 1'b0;
    clr_exit       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (pend_exit_q) begin
          clr_exit = 1'b1;
          if (occ_q[exit_idx_q]) begin
            occ_d[exit_idx_q] = 1'b0;
            exit_done_d       = 1'b1;
            cnt_d             = C_GATE_LOAD;
            exit_gate_d       = 1'b1;
            state_d           = ST_EXIT_OPEN;
          end else begin
            exit_error_d = 1'b1;
          end
        end else if (pend_entry_q) begin
          clr_entry = 1'b1;
          if (full_q) begin
            entry_denied_d = 1'b1;
          end else begin
            occ_d[free_idx] = 1'b1;
            entry_slot_d    = free_idx;
            entry_loc_d     = 8'b1 << free_idx;
            entry_grant_d   = 1'b1;
            cnt_d           = C_GATE_LOAD;
            entry_gate_d    = 1'b1;
            state_d         = ST_ENTRY_OPEN;
          end
        end
      end
      ST_ENTRY_OPEN, ST_EXIT_OPEN: begin
        if (cnt_q == 4'd0) begin
          state_d      = ST_IDLE;
          entry_gate_d = 1'b0;
          exit_gate_d  = 1'b0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d      = ST_IDLE;
        entry_gate_d = 1'b0;
        exit_gate_d  = 1'b0;
      end
    endcase

    // A new pulse on the same edge as a service clear is kept; otherwise a
    // pulse against an already-set flag is dropped.
    pend_entry_d = entry_req | (pend_entry_q & ~clr_entry);
    pend_exit_d  = exit_req  | (pend_exit_q  & ~clr_exit);
    exit_idx_d   = (exit_req && (!pend_exit_q || clr_exit)) ? exit_number : exit_idx_q;

    ones_d = 4'd0;
    for (int i = 0; i < 8; i++) begin
      ones_d = ones_d + {3'b000, occ_d[i]};
    end
    free_count_d = 4'd8 - ones_d;
    full_d       = &occ_d;
    empty_d      = ~|occ_d;
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      cnt_q          <= 4'd0;
      pend_entry_q   <= 1'b0;
      pend_exit_q    <= 1'b0;
      exit_idx_q     <= 3'd0;
      occ_q          <= 8'h00;
      free_count_q   <= 4'd8;
      full_q         <= 1'b0;
      empty_q        <= 1'b1;
      entry_grant_q  <= 1'b0;
      entry_denied_q <= 1'b0;
      exit_done_q    <= 1'b0;
      exit_error_q   <= 1'b0;
      entry_gate_q   <= 1'b0;
      exit_gate_q    <= 1'b0;
      entry_slot_q   <= 3'd0;
      entry_loc_q    <= 8'h00;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      pend_entry_q   <= pend_entry_d;
      pend_exit_q    <= pend_exit_d;
      exit_idx_q     <= exit_idx_d;
      occ_q          <= occ_d;
      free_count_q   <= free_count_d;
      full_q         <= full_d;
      empty_q        <= empty_d;
      entry_grant_q  <= entry_grant_d;
      entry_denied_q <= entry_denied_d;
      exit_done_q    <= exit_done_d;
      exit_error_q   <= exit_error_d;
      entry_gate_q   <= entry_gate_d;
      exit_gate_q    <= exit_gate_d;
      entry_slot_q   <= entry_slot_d;
      entry_loc_q    <= entry_loc_d;
    end
  end

  assign entry_grant    = entry_grant_q;
  assign entry_denied   = entry_denied_q;
  assign entry_slot     = entry_slot_q;
  assign entry_location = entry_loc_q;
  assign exit_done      = exit_done_q;
  assign exit_error     = exit_error_q;
  assign entry_gate     = entry_gate_q;
  assign exit_gate      = exit_gate_q;
  assign occupancy      = occ_q;
  assign free_count     = free_count_q;
  assign full           = full_q;
  assign empty          = empty_q;

endmodule
`default_nettype wire

// File: tb/tb_parking_slot_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_parking_slot_controller
// Purpose  : Self-checking bench for parking_slot_controller. Directed steps
//            followed by random traffic, compared cycle by cycle against a
//            behavioural lot model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_parking_slot_controller;

  localparam int GATE = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       entry_req = 1'b0;
  logic       exit_req = 1'b0;
  logic [2:0] exit_number = 3'd0;
  logic       entry_grant, entry_denied, exit_done, exit_error;
  logic       entry_gate, exit_gate, full, empty;
  logic [2:0] entry_slot;
  logic [7:0] entry_location, occupancy;
  logic [3:0] free_count;

  int n_checks = 0;
  int n_fail   = 0;

  parking_slot_controller #(.GATE_CYCLES(GATE)) dut (
    .clk(clk), .reset(reset),
    .entry_req(entry_req), .exit_req(exit_req), .exit_number(exit_number),
    .entry_grant(entry_grant), .entry_denied(entry_denied),
    .entry_slot(entry_slot), .entry_location(entry_location),
    .exit_done(exit_done), .exit_error(exit_error),
    .entry_gate(entry_gate), .exit_gate(exit_gate),
    .occupancy(occupancy), .free_count(free_count),
    .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  // Behavioural model: a lot of eight parking bays, two request queues of
  // depth one, and a remaining-open-time for whichever gate is up.
  bit m_bay[8];
  bit m_want_in, m_want_out;
  int m_out_bay;
  int m_open_left;
  bit m_open_is_entry;
  int m_last_slot;
  bit m_grant, m_denied, m_done, m_err;

  function automatic int cars_parked();
    int n = 0;
    for (int i = 0; i < 8; i++) n += m_bay[i];
    return n;
  endfunction

  function automatic logic [7:0] bay_map();
    logic [7:0] v = '0;
    for (int i = 0; i < 8; i++) v[i] = m_bay[i];
    return v;
  endfunction

  task automatic model_edge(input bit e, input bit x, input int n, input bit r);
    m_grant = 0; m_denied = 0; m_done = 0; m_err = 0;
    if (r) begin
      foreach (m_bay[i]) m_bay[i] = 0;
      m_want_in = 0; m_want_out = 0; m_out_bay = 0;
      m_open_left = 0; m_last_slot = 0;
      return;
    end
    if (m_open_left > 0) begin
      m_open_left--;
    end else if (m_want_out) begin
      m_want_out = 0;
      if (m_bay[m_out_bay]) begin
        m_bay[m_out_bay] = 0; m_done = 1;
        m_open_left = GATE; m_open_is_entry = 0;
      end else begin
        m_err = 1;
      end
    end else if (m_want_in) begin
      m_want_in = 0;
      if (cars_parked() == 8) begin
        m_denied = 1;
      end else begin
        int k = 0;
        while (m_bay[k]) k++;
        m_bay[k] = 1; m_last_slot = k; m_grant = 1;
        m_open_left = GATE; m_open_is_entry = 1;
      end
    end
    if (e && !m_want_in) m_want_in = 1;
    if (x && !m_want_out) begin
      m_want_out = 1; m_out_bay = n;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("entry_grant",    32'(entry_grant),    32'(m_grant));
    chk("entry_denied",   32'(entry_denied),   32'(m_denied));
    chk("exit_done",      32'(exit_done),      32'(m_done));
    chk("exit_error",     32'(exit_error),     32'(m_err));
    chk("entry_slot",     32'(entry_slot),     32'(m_last_slot));
    chk("entry_location", 32'(entry_location), (cars_parked() == 0 && m_last_slot == 0 && entry_location == 8'h00) ? 32'h0 : 32'(1) << m_last_slot);
    chk("entry_gate",     32'(entry_gate),     32'(m_open_left > 0 && m_open_is_entry));
    chk("exit_gate",      32'(exit_gate),      32'(m_open_left > 0 && !m_open_is_entry));
    chk("occupancy",      32'(occupancy),      32'(bay_map()));
    chk("free_count",     32'(free_count),     32'(8 - cars_parked()));
    chk("full",           32'(full),           32'(cars_parked() == 8));
    chk("empty",          32'(empty),          32'(cars_parked() == 0));
  endtask

  task automatic step(input bit e, input bit x, input int n, input bit r);
    entry_req = e; exit_req = x; exit_number = 3'(n); reset = r;
    @(posedge clk);
    model_edge(e, x, n, r);
    #1;
    check_all();
    entry_req = 1'b0; exit_req = 1'b0; reset = 1'b0;
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) step(0, 0, 0, 0);
  endtask

  initial begin
    m_open_is_entry = 0;
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    chk("reset_free_count", 32'(free_count), 32'd8);
    chk("reset_empty", 32'(empty), 32'd1);

    // First entry: grant two edges after the request, slot 0.
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("first_grant", 32'(entry_grant), 32'd1);
    chk("first_location", 32'(entry_location), 32'h01);
    idle(5);
    chk("first_occupancy", 32'(occupancy), 32'h01);
    chk("first_free", 32'(free_count), 32'd7);

    // Three more entries give 8'h0F, then exit slot 2 and refill it.
    for (int i = 0; i < 3; i++) begin step(1, 0, 0, 0); idle(6); end
    chk("occ_0f", 32'(occupancy), 32'h0F);
    step(0, 1, 2, 0); idle(6);
    chk("occ_0b", 32'(occupancy), 32'h0B);
    step(1, 0, 0, 0); idle(6);
    chk("refill_slot2", 32'(entry_slot), 32'd2);

    // Exit naming empty slot 6 is an error with no gate time.
    step(0, 1, 6, 0); step(0, 0, 0, 0);
    chk("exit_error_6", 32'(exit_error), 32'd1);
    idle(2);

    // Fill the lot, then a ninth entry is denied.
    for (int i = 0; i < 4; i++) begin step(1, 0, 0, 0); idle(6); end
    chk("full_flag", 32'(full), 32'd1);
    step(1, 0, 0, 0); step(0, 0, 0, 0);
    chk("denied", 32'(entry_denied), 32'd1);
    idle(2);

    // Simultaneous exit 5 and entry on a full lot: exit first, then slot 5.
    step(1, 1, 5, 0); idle(8);
    chk("swap_slot5", 32'(entry_slot), 32'd5);
    chk("swap_full", 32'(occupancy), 32'hFF);
    idle(4);

    // Reset in the second ENTRY_OPEN cycle with an exit pending.
    step(0, 1, 0, 1);
    step(0, 1, 3, 0); idle(6);
    step(1, 0, 0, 0); step(0, 0, 0, 0); step(0, 1, 0, 0);
    step(0, 0, 0, 1);
    idle(8);
    chk("post_reset_occ", 32'(occupancy), 32'h00);

    // Random traffic in entry-heavy, mixed and exit-heavy phases.
    for (int ph = 0; ph < 3; ph++) begin
      for (int i = 0; i < 400; i++) begin
        bit e, x, r;
        e = ($urandom_range(99) < (ph == 0 ? 60 : (ph == 1 ? 30 : 10)));
        x = ($urandom_range(99) < (ph == 0 ? 10 : (ph == 1 ? 30 : 50)));
        r = ($urandom_range(999) < 3);
        step(e, x, int'($urandom_range(7)), r);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
